// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the bcd_sched conversion scheduler
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_sched_state_t;

  // Double-dabble correction: a digit of 5 or more would reach 10+ after the
  // next doubling, so it is pre-biased by 3 to carry into the next digit.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Number of decimal digits needed to represent 2^n-1 (n up to 63)
  function automatic int bcd_digits(input int n);
    longint unsigned v;
    int d;
    v = (64'd1 << n) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        v = v / 10;
        d++;
      end
    end
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one-digit add-3 correction for the shift-and-add-3 engine
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Inputs are always <= 9, so the adjusted digit is at most 12 and fits 4 bits
  assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bcd_sched.sv
// rtl/bcd_sched.sv - round-robin scheduler sharing one iterative binary-to-BCD engine; BCD_SCHED_PERF_EN adds perf_done
module bcd_sched
  import bcd_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NREQ-1:0]                           req_valid,
  input  logic [NREQ*N-1:0]                         req_data,
  output logic [NREQ-1:0]                           req_ready,
  output logic                                      rsp_valid,
  input  logic                                      rsp_ready,
  output logic [4*bcd_digits(N)-1:0]                rsp_bcd,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
`ifdef BCD_SCHED_PERF_EN
  output logic [31:0]                               perf_done,
`endif
  output logic                                      busy
);

  localparam int D   = bcd_digits(N);
  localparam int SW  = 4 * D + N;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(N + 1);

  bcd_sched_state_t state, state_next;

  logic [SW-1:0]  sreg;
  logic [SW-1:0]  sreg_adj;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic [IDW-1:0] id_reg;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan_idx;
  logic [N-1:0]   grant_data;
  logic           grant_found;
  logic [CW-1:0]  cnt;
  logic           shift_last;
  int             scan_sum;

  // Rotating-priority search: first valid requester starting at ptr, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_sum    = 0;
    scan_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_sum = int'(ptr) + i;
      if (scan_sum >= NREQ) scan_sum = scan_sum - NREQ;
      scan_idx = IDW'(scan_sum);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Data of the granted requester and the pointer value just past it
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant_idx) grant_data = req_data[i*N +: N];
    end
    ptr_next = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
  end

  assign sreg_adj[N-1:0] = sreg[N-1:0];

  for (genvar k = 0; k < D; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sreg[N+4*k +: 4]),
      .dout (sreg_adj[N+4*k +: 4])
    );
  end

  assign shift_last = (cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_found) state_next = SHIFT;
      SHIFT:   if (shift_last)  state_next = DONE;
      DONE:    if (rsp_ready)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on grant, adjust-then-shift once per SHIFT cycle, hold in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg   <= '0;
      id_reg <= '0;
      cnt    <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            sreg   <= {{(4*D){1'b0}}, grant_data};
            id_reg <= grant_idx;
            cnt    <= '0;
            ptr    <= ptr_next;
          end
        end
        SHIFT: begin
          sreg <= sreg_adj << 1;
          cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: grant only in IDLE and never while reset is held
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
    rsp_valid = (state == DONE);
    busy      = (state != IDLE);
    rsp_bcd   = sreg[SW-1:N];
    rsp_id    = id_reg;
  end

`ifdef BCD_SCHED_PERF_EN
  // Count of completed response handshakes, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst)                        perf_done <= '0;
    else if (rsp_valid & rsp_ready) perf_done <= perf_done + 32'd1;
  end
`endif

endmodule

// File: doc/bcd_sched.md
# bcd_sched

Round-robin scheduler and sequencer that shares one iterative binary-to-BCD conversion engine between `NREQ` requesters. It arbitrates among valid requests, runs a shift-and-add-3 (double-dabble) sequence over `N` cycles, and returns the packed BCD result tagged with the requester index. It sits between several binary producers (counters, display feeders) and a single BCD consumer, replacing one combinational converter per requester.

## Interface
- `N`, 8: binary input width, N ≥ 4.
- `NREQ`, 4: number of requesters, NREQ ≥ 2.
- `D`, derived, not overridable: number of decimal digits of 2^N−1 (N=8 → 3).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: per-requester request.
- `req_data` in NREQ*N: requester i occupies bits [i*N +: N].
- `req_ready` out NREQ: one-hot grant; a transfer occurs on `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_bcd` out 4*D: packed BCD, digit k in bits [4k+3:4k], with the least significant digit at k=0.
- `rsp_id` out max(1,$clog2(NREQ)): index of the requester that owns the result.
- `busy` out 1: high in SHIFT and DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `req_ready` is combinational from `req_valid` and the pointer `ptr`.
  - The grant goes to the first valid index scanning `ptr`, `ptr`+1, … with wrap-around modulo NREQ.
  - On a grant:
    - load the shift register with {4*D zeros, `req_data[g]`};
    - latch `g` into the id register;
    - clear the iteration counter;
    - set `ptr` ← (g+1) mod NREQ;
    - go to SHIFT.
  - With no valid request, stay in IDLE.
- SHIFT, one iteration per cycle:
  - Every BCD digit ≥ 5 gets +3 (4-bit result).
  - Then the whole {bcd, bin} register shifts left by 1.
  - After N iterations, go to DONE.
  - The counter is $clog2(N+1) bits and never wraps within an operation.
- DONE:
  - `rsp_valid` = 1.
  - `rsp_bcd` and `rsp_id` are held stable until `rsp_valid & rsp_ready`, then go to IDLE.
  - `req_ready` = 0 in SHIFT and DONE.
- Requests arriving while busy wait; a requester must hold `req_valid` and `req_data` stable until granted.
- Digit arithmetic never overflows: each digit is ≤ 9 after the shift, because adjusted digits are ≤ 12 before the shift.

## Timing
- Reset values:
  - state IDLE, `ptr` 0;
  - `rsp_valid` 0, `rsp_bcd` 0, `rsp_id` 0, `busy` 0;
  - `req_ready` 0 while `rst` is high.
- Accept in cycle t → SHIFT in cycles t+1 … t+N → `rsp_valid` first high in cycle t+N+1.
- With `rsp_ready` held high, the response completes at t+N+1 and the next accept can occur at t+N+2. Peak throughput is one conversion per N+2 cycles.
- Simultaneous requests: exactly one grant per accept; the others are served in rotation order over later accepts.
- `rst` asserted in any state: the next cycle is IDLE with all outputs at reset values. The interrupted conversion is discarded and its requester is not re-granted unless it is still valid.
- `rsp_ready` high outside DONE has no effect.

## Configuration
- `BCD_SCHED_PERF_EN` defined:
  - adds output `perf_done` (32 bits), a count of completed responses (`rsp_valid & rsp_ready`);
  - resets to 0 and wraps modulo 2^32.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Package `bcd_pkg`:
  - state enum `bcd_sched_state_t` (IDLE, SHIFT, DONE);
  - constant function `bcd_digits(n)` returning D;
  - localparam `BCD_ADJ_THRESH` = 5 and `BCD_ADJ_ADD` = 3.
- Sub-module `bcd_digit_adj`: combinational, 4-bit in / 4-bit out, adds 3 when the input is ≥ 5. Instantiated D times in a generate loop.
- Arbiter, FSM, counter and shift register stay in `bcd_sched`.

## Test plan
- N=8, NREQ=4: `req_valid`=4'b0100, `req_data[2]`=8'd255 → `rsp_bcd`=12'h255, `rsp_id`=2, `rsp_valid` high exactly 9 cycles after the accept.
- Sequential single requests 8'd0, 8'd9, 8'd10, 8'd99, 8'd128 → 12'h000, 12'h009, 12'h010, 12'h099, 12'h128. Also compare all 256 values against a reference model.
- All four requesters valid and held from reset → grants and `rsp_id` in the order 0, 1, 2, 3, 0. `req_ready` is never two bits hot and is 0 while `busy`=1.
- `rsp_ready` held low for 5 cycles in DONE → `rsp_valid`, `rsp_bcd` and `rsp_id` stable, no grant. Raising `rsp_ready` → IDLE next cycle and a pending request is granted that cycle.
- `rst` pulsed on the 4th SHIFT cycle → IDLE next cycle, `rsp_valid`=0, `ptr`=0. A still-valid requester 3 (with 0–2 idle) is granted next and returns a correct result.
- `BCD_SCHED_PERF_EN` defined: 3 completed responses → `perf_done`=3. `rst` → `perf_done`=0.
